// File: rtl/iq_flow_ctrl.sv
// iq_flow_ctrl: flow control between fetch, an instruction queue and decode.
// Tracks queue occupancy, throttles fetch near full, and blocks fetch/decode
// for FLUSH_HOLD cycles after a pipeline flush. It also cross-checks its own
// occupancy against the count the queue reports.
// Optional feature: define IQ_PERF_CNT_EN to build the fetch-stall
// performance counter. Without it, stall_cycles is tied to zero.
module iq_flow_ctrl #(
  parameter int SIZE       = 128,
  parameter int FLUSH_HOLD = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_valid,
  input  logic                   fetch_two,
  output logic                   fetch_stall,
  input  logic                   dec_ready,
  output logic                   dec_valid,
  input  logic                   flush_valid,
  input  logic [31:0]            q_num_items,
  output logic                   q_enq,
  output logic                   q_deq,
  output logic                   q_num_enq,
  output logic                   q_flush,
  output logic [$clog2(SIZE):0]  occ,
  output logic                   occ_err,
  output logic [31:0]            stall_cycles
);

  localparam int OCC_W = $clog2(SIZE) + 1;
  // Fetch may deliver two entries per cycle, so it stops with two slots left.
  localparam logic [OCC_W-1:0] STALL_THR = OCC_W'(SIZE - 3);
  localparam logic [3:0]       HOLD_INIT = 4'(FLUSH_HOLD - 1);

  typedef enum logic {
    ST_RUN,
    ST_HOLD
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_hold_cnt;
  logic [3:0]       w_hold_nxt;
  logic [OCC_W-1:0] r_occ;
  logic [OCC_W-1:0] w_occ_nxt;
  logic             r_occ_err;
  logic             w_occ_err_nxt;

  logic             w_run;
  logic             w_fetch_stall;
  logic             w_enq;
  logic             w_enq_two;
  logic             w_dec_valid;
  logic             w_deq;
  logic [OCC_W-1:0] w_enq_cnt;

  // Handshake decode and next-state computation for state, hold count,
  // occupancy and the sticky mismatch flag.
  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_run         = (r_state == ST_RUN);
    // While reset is asserted fetch is held off and every queue control is 0.
    w_fetch_stall = ~rst | ~w_run | (r_occ > STALL_THR);
    w_enq         = rst & fetch_valid & ~w_fetch_stall & ~flush_valid;
    w_enq_two     = w_enq & fetch_two;
    w_dec_valid   = rst & w_run & (r_occ != '0) & ~flush_valid;
    w_deq         = w_dec_valid & dec_ready;
    w_enq_cnt     = w_enq ? (w_enq_two ? OCC_W'(2) : OCC_W'(1)) : '0;

    w_state_nxt   = r_state;
    w_hold_nxt    = r_hold_cnt;
    w_occ_nxt     = r_occ + w_enq_cnt - OCC_W'(w_deq);
    w_occ_err_nxt = r_occ_err;

    if (flush_valid) begin
      // A flush empties the queue and (re)starts the hold window from any state.
      w_state_nxt = ST_HOLD;
      w_hold_nxt  = HOLD_INIT;
      w_occ_nxt   = '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (32'(r_occ) != q_num_items) begin
            w_occ_err_nxt = 1'b1;
          end
        end
        ST_HOLD: begin
          if (r_hold_cnt == '0) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_hold_nxt = r_hold_cnt - 4'd1;
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  // State, hold count, occupancy and error flag registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_RUN;
      r_hold_cnt <= '0;
      r_occ      <= '0;
      r_occ_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_occ      <= w_occ_nxt;
      r_occ_err  <= w_occ_err_nxt;
    end
  end

`ifdef IQ_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic        w_stall_inc;

  assign w_stall_inc = fetch_valid & w_fetch_stall;

  // Saturating count of cycles where fetch offered work but was refused;
  // only reset clears it, a flush leaves it untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cycles <= '0;
    end else if (w_stall_inc && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = '0;
`endif

  assign fetch_stall = w_fetch_stall;
  assign q_enq       = w_enq;
  assign q_num_enq   = w_enq_two;
  assign dec_valid   = w_dec_valid;
  assign q_deq       = w_deq;
  assign q_flush     = rst & flush_valid;
  assign occ         = r_occ;
  assign occ_err     = r_occ_err;

endmodule
